// File: rtl/universal_shift_engine.sv
// Frame-based universal shift register: PIPO/PISO/SIPO/SISO with selectable frame
// length, LSB/MSB-first ordering, start/busy/done handshake and synchronous abort.
module universal_shift_engine #(
    parameter int DW = 8,
    parameter int LW = $clog2(DW + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic          msb_first,
    input  logic [LW-1:0] len,
    input  logic          shift_en,
    input  logic          abort,
    input  logic [DW-1:0] par_in,
    input  logic          ser_in,
    output logic [DW-1:0] par_out,
    output logic          ser_out,
    output logic          busy,
    output logic          done,
    output logic [LW-1:0] bit_cnt
);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    localparam logic [1:0]    M_PIPO = 2'd0;
    localparam logic [1:0]    M_PISO = 2'd1;
    localparam logic [1:0]    M_SIPO = 2'd2;
    localparam logic [1:0]    M_SISO = 2'd3;
    localparam logic [LW-1:0] DW_L   = LW'(DW);

    // A zero or oversized request means a full-width frame.
    function automatic logic [LW-1:0] eff_len(input logic [LW-1:0] l);
        if (l == '0 || l > DW_L) return DW_L;
        return l;
    endfunction

    function automatic logic [DW-1:0] len_mask(input logic [LW-1:0] l);
        logic [DW-1:0] m;
        for (int i = 0; i < DW; i++) m[i] = (i < int'(l));
        return m;
    endfunction

    // Shift only the low l bits; bits at and above l come out as 0.
    function automatic logic [DW-1:0] shift_frame(input logic [DW-1:0] r,
                                                  input logic [LW-1:0] l,
                                                  input logic          msb,
                                                  input logic          in_bit);
        logic [DW-1:0] n;
        n = '0;
        for (int i = 0; i < DW; i++) begin
            if (msb) begin
                if (i == 0)           n[i] = in_bit;
                else if (i < int'(l)) n[i] = r[(i + DW - 1) % DW];
            end else begin
                if (i == int'(l) - 1)     n[i] = in_bit;
                else if (i < int'(l) - 1) n[i] = r[(i + 1) % DW];
            end
        end
        return n;
    endfunction

    function automatic logic out_bit(input logic [DW-1:0] r,
                                     input logic [LW-1:0] l,
                                     input logic          msb);
        logic b;
        b = 1'b0;
        for (int i = 0; i < DW; i++) begin
            if (msb ? (i == int'(l) - 1) : (i == 0)) b = r[i];
        end
        return b;
    endfunction

    state_t          state_q, state_d;
    logic [1:0]      mode_q;
    logic            msb_q;
    logic [LW-1:0]   len_q;
    logic [LW-1:0]   bit_cnt_q;
    logic [DW-1:0]   sreg_q;
    logic [DW-1:0]   par_out_q;
    logic            ser_out_q;
    logic            done_q;

    logic            accept;
    logic            do_shift;
    logic            last_shift;
    logic            in_bit;
    logic [DW-1:0]   shifted;

    always_comb begin
        accept     = (state_q == IDLE) && start;
        do_shift   = (state_q == SHIFT) && shift_en && !abort;
        last_shift = do_shift && (bit_cnt_q == len_q - LW'(1));
        in_bit     = (mode_q == M_SIPO || mode_q == M_SISO) ? ser_in : 1'b0;
        shifted    = shift_frame(sreg_q, len_q, msb_q, in_bit);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && mode != M_PIPO) state_d = SHIFT;
            SHIFT:   if (abort || last_shift)      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q    <= '0;
            msb_q     <= 1'b0;
            len_q     <= '0;
            bit_cnt_q <= '0;
            sreg_q    <= '0;
            par_out_q <= '0;
            ser_out_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                mode_q    <= mode;
                msb_q     <= msb_first;
                len_q     <= eff_len(len);
                bit_cnt_q <= '0;
                case (mode)
                    M_PIPO: begin
                        par_out_q <= par_in;
                        done_q    <= 1'b1;
                    end
                    M_PISO, M_SISO: sreg_q <= par_in & len_mask(eff_len(len));
                    M_SIPO:         sreg_q <= '0;
                    default:        sreg_q <= '0;
                endcase
            end else if (state_q == SHIFT && abort) begin
                bit_cnt_q <= '0;
            end else if (do_shift) begin
                sreg_q <= shifted;
                if (mode_q == M_PISO || mode_q == M_SISO)
                    ser_out_q <= out_bit(sreg_q, len_q, msb_q);
                if (last_shift) begin
                    bit_cnt_q <= '0;
                    done_q    <= 1'b1;
                    if (mode_q == M_SIPO || mode_q == M_SISO) par_out_q <= shifted;
                end else begin
                    bit_cnt_q <= bit_cnt_q + LW'(1);
                end
            end
        end
    end

    assign par_out = par_out_q;
    assign ser_out = ser_out_q;
    assign busy    = (state_q == SHIFT);
    assign done    = done_q;
    assign bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_universal_shift_engine.sv
// Directed self-checking bench for universal_shift_engine (DW=8).
module tb_universal_shift_engine;

    localparam int DW = 8;
    localparam int LW = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic [1:0]    mode;
    logic          msb_first;
    logic [LW-1:0] len;
    logic          shift_en;
    logic          abort;
    logic [DW-1:0] par_in;
    logic          ser_in;
    logic [DW-1:0] par_out;
    logic          ser_out;
    logic          busy;
    logic          done;
    logic [LW-1:0] bit_cnt;

    int checks = 0;
    int errors = 0;

    universal_shift_engine #(.DW(DW), .LW(LW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .msb_first(msb_first),
        .len      (len),
        .shift_en (shift_en),
        .abort    (abort),
        .par_in   (par_in),
        .ser_in   (ser_in),
        .par_out  (par_out),
        .ser_out  (ser_out),
        .busy     (busy),
        .done     (done),
        .bit_cnt  (bit_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] pat;
    logic [4:0] sin5;
    logic [3:0] bits4;

    initial begin
        rst = 1'b0; start = 1'b0; mode = 2'd0; msb_first = 1'b0; len = '0;
        shift_en = 1'b0; abort = 1'b0; par_in = '0; ser_in = 1'b0;
        tick(); tick();
        chk("rst_par_out", 32'(par_out), 32'h0);
        chk("rst_ser_out", 32'(ser_out), 32'h0);
        chk("rst_busy",    32'(busy),    32'h0);
        chk("rst_done",    32'(done),    32'h0);
        chk("rst_bit_cnt", 32'(bit_cnt), 32'h0);
        rst = 1'b1;
        tick();

        // PISO LSB-first, full frame via len=0
        mode = 2'd1; msb_first = 1'b0; len = 4'd0; par_in = 8'hA5; shift_en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("piso_busy", 32'(busy), 32'h1);
        chk("piso_cnt0", 32'(bit_cnt), 32'h0);
        pat = 8'hA5;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("piso_ser", 32'(ser_out), 32'(pat[k]));
            if (k == 2) chk("piso_cnt3", 32'(bit_cnt), 32'h3);
            if (k == 6) chk("piso_nodone", 32'(done), 32'h0);
        end
        chk("piso_done", 32'(done), 32'h1);
        chk("piso_idle", 32'(busy), 32'h0);
        chk("piso_par",  32'(par_out), 32'h0);
        tick();
        chk("piso_done_pulse", 32'(done), 32'h0);

        // SIPO MSB-first, len=5
        mode = 2'd2; msb_first = 1'b1; len = 4'd5; start = 1'b1;
        tick();
        start = 1'b0;
        sin5 = 5'b10011;
        for (int k = 0; k < 5; k++) begin
            ser_in = sin5[k];
            tick();
        end
        chk("sipo_msb_par",  32'(par_out), 32'h19);
        chk("sipo_msb_done", 32'(done), 32'h1);
        tick();
        chk("sipo_msb_pulse", 32'(done), 32'h0);

        // SIPO LSB-first, len=4
        mode = 2'd2; msb_first = 1'b0; len = 4'd4; start = 1'b1;
        tick();
        start = 1'b0;
        bits4 = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            ser_in = bits4[k];
            tick();
        end
        chk("sipo_lsb_par",  32'(par_out), 32'h01);
        chk("sipo_lsb_done", 32'(done), 32'h1);

        // SISO MSB-first, len=4, gated shift_en
        mode = 2'd3; msb_first = 1'b1; len = 4'd4; par_in = 8'h0C; ser_in = 1'b1;
        shift_en = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        bits4 = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            shift_en = 1'b1;
            tick();
            chk("siso_ser_en", 32'(ser_out), 32'(bits4[k]));
            chk("siso_cnt_en", 32'(bit_cnt), (k == 3) ? 32'h0 : 32'(k + 1));
            if (k == 3) begin
                chk("siso_done", 32'(done), 32'h1);
                chk("siso_par",  32'(par_out), 32'h0F);
            end
            shift_en = 1'b0;
            tick();
            chk("siso_ser_hold", 32'(ser_out), 32'(bits4[k]));
            chk("siso_cnt_hold", 32'(bit_cnt), (k == 3) ? 32'h0 : 32'(k + 1));
        end

        // PIPO
        mode = 2'd0; par_in = 8'h3C; start = 1'b1;
        tick();
        start = 1'b0;
        chk("pipo_par",  32'(par_out), 32'h3C);
        chk("pipo_done", 32'(done), 32'h1);
        chk("pipo_busy", 32'(busy), 32'h0);
        tick();
        chk("pipo_pulse", 32'(done), 32'h0);

        // start while busy is ignored; mode change mid-frame has no effect
        mode = 2'd1; msb_first = 1'b0; len = 4'd2; par_in = 8'h02; shift_en = 1'b0; start = 1'b1;
        tick();
        chk("bb_busy", 32'(busy), 32'h1);
        mode = 2'd0; par_in = 8'hFF;
        tick();
        start = 1'b0;
        chk("bb_ign_busy", 32'(busy), 32'h1);
        chk("bb_ign_done", 32'(done), 32'h0);
        chk("bb_ign_par",  32'(par_out), 32'h3C);
        shift_en = 1'b1;
        tick();
        chk("bb_ser0", 32'(ser_out), 32'h0);
        chk("bb_cnt1", 32'(bit_cnt), 32'h1);
        tick();
        chk("bb_ser1", 32'(ser_out), 32'h1);
        chk("bb_done", 32'(done), 32'h1);
        chk("bb_par",  32'(par_out), 32'h3C);
        // start in the done cycle: SIPO LSB-first len=2
        mode = 2'd2; msb_first = 1'b0; len = 4'd2; ser_in = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_busy", 32'(busy), 32'h1);
        chk("b2b_done_clr", 32'(done), 32'h0);
        tick();
        chk("b2b_cnt1", 32'(bit_cnt), 32'h1);
        tick();
        chk("b2b_done", 32'(done), 32'h1);
        chk("b2b_par",  32'(par_out), 32'h03);

        // abort after 3 shifts
        mode = 2'd1; msb_first = 1'b0; len = 4'd0; par_in = 8'hFF; shift_en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("ab_cnt3", 32'(bit_cnt), 32'h3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_busy", 32'(busy), 32'h0);
        chk("ab_done", 32'(done), 32'h0);
        chk("ab_ser",  32'(ser_out), 32'h1);
        chk("ab_par",  32'(par_out), 32'h03);
        chk("ab_cnt",  32'(bit_cnt), 32'h0);
        tick();
        chk("ab_nodone", 32'(done), 32'h0);

        // abort together with start in IDLE: start wins
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("abst_busy", 32'(busy), 32'h1);
        tick(); tick(); tick();
        chk("rs_cnt3", 32'(bit_cnt), 32'h3);
        // asynchronous reset mid-frame
        #2;
        rst = 1'b0;
        #1;
        chk("rs_par",  32'(par_out), 32'h0);
        chk("rs_ser",  32'(ser_out), 32'h0);
        chk("rs_busy", 32'(busy), 32'h0);
        chk("rs_done", 32'(done), 32'h0);
        chk("rs_cnt",  32'(bit_cnt), 32'h0);
        tick();
        rst = 1'b1;
        tick();
        chk("rs_nodone", 32'(done), 32'h0);
        chk("rs_idle",   32'(busy), 32'h0);

        // len above DW means a full 8-bit frame
        mode = 2'd2; msb_first = 1'b1; len = 4'd12; ser_in = 1'b1; shift_en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        chk("big_busy7", 32'(busy), 32'h1);
        tick();
        chk("big_done", 32'(done), 32'h1);
        chk("big_par",  32'(par_out), 32'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
